regfile_loader: RTL and testbench
=================================

REGFILE_LOADER -- requirements
Module: regfile_loader

Interface
REQ-001 Parameter NUM_A, 8, number of register-file-A entries written per load (3-bit address space).
REQ-002 Parameter NUM_B, 16, number of register-file-B entries written per load (4-bit address space).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load_req  input  1  single-cycle request to begin a load sequence.
REQ-006 in_data  input  8  stream byte.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader can accept a byte this cycle.
REQ-009 WriteRegA  output  3  register-file-A write address.
REQ-010 WriteDataA  output  4  register-file-A write data.
REQ-011 WriteEnA  output  1  register-file-A write enable.
REQ-012 WriteRegB  output  4  register-file-B write address.
REQ-013 WriteDataB  output  8  register-file-B write data.
REQ-014 WriteEnB  output  1  register-file-B write enable.
REQ-015 start  output  1  level enable to adder/comparator datapath.
REQ-016 busy  output  1  high in any load state.
REQ-017 err  output  1  sticky checksum-failure flag (constant 0 without CHECKSUM_EN).

Function
REQ-018 FSM states: IDLE, LOAD_A, LOAD_B, CHECK (only with CHECKSUM_EN), RUN.
REQ-019 IDLE or RUN + load_req -> LOAD_A next cycle; address counter cleared; start low from that cycle; err cleared.
REQ-020 load_req while busy is ignored.
REQ-021 Byte transfer occurs in a cycle with in_valid and in_ready both high; in_ready high only in LOAD_A, LOAD_B, CHECK.
REQ-022 LOAD_A: each transfer writes in_data[3:0] to address = counter; in_data[7:4] ignored; after NUM_A-th transfer -> LOAD_B, counter cleared.
REQ-023 LOAD_B: each transfer writes in_data[7:0] to address = counter; after NUM_B-th transfer -> CHECK (with macro) or RUN (without).
REQ-024 Write ports registered: transfer in cycle N gives WriteEn high with address/data in cycle N+1 only; WriteEn low otherwise; WriteEnA and WriteEnB never high together.
REQ-025 Counters wrap is impossible by construction; counter never exceeds NUM-1.
REQ-026 Cycles with in_valid low stall the sequence with no write and no state change.
REQ-027 RUN: start held high until load_req or reset; in_ready low.
REQ-028 busy = state in {LOAD_A, LOAD_B, CHECK}.

Reset
REQ-029 rst low asynchronously forces IDLE, counters 0, in_ready 0, all WriteEn 0, addresses/data 0, start 0, busy 0, err 0, checksum 0.
REQ-030 Reset mid-load abandons the sequence; already-performed register writes are not undone; no further writes issued.

Configuration
REQ-031 Macro REGFILE_LOADER_CHECKSUM_EN: when defined, XOR of all NUM_A+NUM_B accepted bytes accumulates; CHECK accepts one extra byte; match -> RUN; mismatch -> IDLE with err set, start stays low.
REQ-032 Without the macro, CHECK state and accumulator are absent, LOAD_B goes directly to RUN, err tied 0.

Structure
REQ-033 Shared package holds the state enumeration, NUM_A/NUM_B defaults, and address widths 3 and 4.
REQ-034 One sub-module, loader_checksum (XOR accumulator with clear/enable), instantiated only under the macro; rest is a single FSM-plus-counter module.

Verification
REQ-035 Load bytes 0x01..0x08 then 0x10..0x1F with in_valid always high -> A addresses 0..7 get 1..8, B addresses 0..15 get 0x10..0x1F, each write one cycle after its transfer, start high the cycle after the last B write (no macro).
REQ-036 Drop in_valid for 3 cycles after the 4th A byte -> no writes during gap, sequence resumes at A address 4.
REQ-037 A byte 0xF7 -> WriteDataA = 0x7.
REQ-038 Reset asserted after 10 transfers -> all outputs 0 immediately; next load_req restarts at A address 0.
REQ-039 With macro, correct XOR byte -> start high; wrong byte (correct XOR ^ 0x01) -> err 1, start 0, state IDLE.
REQ-040 load_req during LOAD_B -> ignored, sequence completes normally; load_req in RUN -> start low next cycle, new load begins.

Source files
------------

// File: rtl/regfile_loader_pkg.sv
// Shared types and sizing for regfile_loader; CHECK state exists only with REGFILE_LOADER_CHECKSUM_EN.
// Write ports lag their byte transfer by one cycle; in_ready is a registered state decode.
package regfile_loader_pkg;

  localparam int NUM_A_DEF = 8;
  localparam int NUM_B_DEF = 16;
  localparam int ADDR_W_A  = 3;
  localparam int ADDR_W_B  = 4;
  localparam int CNT_W     = 4;

`ifdef REGFILE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CHECK,
    ST_RUN
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_RUN
  } state_t;
`endif

  function automatic logic is_load_state(input state_t s);
`ifdef REGFILE_LOADER_CHECKSUM_EN
    return (s == ST_LOAD_A) || (s == ST_LOAD_B) || (s == ST_CHECK);
`else
    return (s == ST_LOAD_A) || (s == ST_LOAD_B);
`endif
  endfunction

endpackage

// File: rtl/regfile_loader_if.sv
// Byte stream in (valid/ready) and the two register-file write ports out.
// master = stream source / register-file side, slave = the loader.
interface regfile_loader_if;
  import regfile_loader_pkg::*;

  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic [ADDR_W_A-1:0] WriteRegA;
  logic [3:0]          WriteDataA;
  logic                WriteEnA;
  logic [ADDR_W_B-1:0] WriteRegB;
  logic [7:0]          WriteDataB;
  logic                WriteEnB;

  modport master (
    output in_data, in_valid,
    input  in_ready, WriteRegA, WriteDataA, WriteEnA, WriteRegB, WriteDataB, WriteEnB
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, WriteRegA, WriteDataA, WriteEnA, WriteRegB, WriteDataB, WriteEnB
  );

endinterface

// File: rtl/regfile_loader_checksum.sv
// XOR accumulator over accepted stream bytes; clear has priority over enable.
// Result visible the cycle after the last enabled byte; no backpressure.
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = 8'h00;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/regfile_loader.sv
// Streams NUM_A nibbles then NUM_B bytes into two register files, then raises start.
// Writes appear one cycle after transfer; in_valid low stalls. Optional REGFILE_LOADER_CHECKSUM_EN.
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int NUM_A = NUM_A_DEF,
  parameter int NUM_B = NUM_B_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_req,
  regfile_loader_if.slave  bus,
  output logic             start,
  output logic             busy,
  output logic             err
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic                wen_a_q, wen_a_d;
  logic [ADDR_W_A-1:0] wreg_a_q, wreg_a_d;
  logic [3:0]          wdat_a_q, wdat_a_d;
  logic                wen_b_q, wen_b_d;
  logic [ADDR_W_B-1:0] wreg_b_q, wreg_b_d;
  logic [7:0]          wdat_b_q, wdat_b_d;
  logic                xfer;
  logic                load_go;
  logic                last_a, last_b;

  assign xfer    = bus.in_valid && in_ready_q;
  assign load_go = load_req && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign last_a  = (cnt_q == CNT_W'(NUM_A - 1));
  assign last_b  = (cnt_q == CNT_W'(NUM_B - 1));

`ifdef REGFILE_LOADER_CHECKSUM_EN
  logic       err_q, err_d;
  logic [7:0] sum;

  loader_checksum u_checksum (
    .clk (clk),
    .rst (rst),
    .clr (load_go),
    .en  (xfer && ((state_q == ST_LOAD_A) || (state_q == ST_LOAD_B))),
    .din (bus.in_data),
    .acc (sum)
  );
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wen_a_d  = 1'b0;
    wreg_a_d = wreg_a_q;
    wdat_a_d = wdat_a_q;
    wen_b_d  = 1'b0;
    wreg_b_d = wreg_b_q;
    wdat_b_d = wdat_b_q;
`ifdef REGFILE_LOADER_CHECKSUM_EN
    err_d    = err_q;
`endif
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_req) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
`ifdef REGFILE_LOADER_CHECKSUM_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD_A: begin
        if (xfer) begin
          wen_a_d  = 1'b1;
          wreg_a_d = cnt_q[ADDR_W_A-1:0];
          wdat_a_d = bus.in_data[3:0];
          if (last_a) begin
            state_d = ST_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (xfer) begin
          wen_b_d  = 1'b1;
          wreg_b_d = cnt_q[ADDR_W_B-1:0];
          wdat_b_d = bus.in_data;
          if (last_b) begin
`ifdef REGFILE_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_RUN;
`endif
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef REGFILE_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (bus.in_data == sum) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // start follows RUN by one cycle and drops as soon as a new load is requested
    start_d    = (state_q == ST_RUN) && !load_req;
    in_ready_d = is_load_state(state_d);
    busy_d     = is_load_state(state_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      wen_a_q    <= 1'b0;
      wreg_a_q   <= '0;
      wdat_a_q   <= '0;
      wen_b_q    <= 1'b0;
      wreg_b_q   <= '0;
      wdat_b_q   <= '0;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      wen_a_q    <= wen_a_d;
      wreg_a_q   <= wreg_a_d;
      wdat_a_q   <= wdat_a_d;
      wen_b_q    <= wen_b_d;
      wreg_b_q   <= wreg_b_d;
      wdat_b_q   <= wdat_b_d;
`ifdef REGFILE_LOADER_CHECKSUM_EN
      err_q      <= err_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.WriteEnA   = wen_a_q;
  assign bus.WriteRegA  = wreg_a_q;
  assign bus.WriteDataA = wdat_a_q;
  assign bus.WriteEnB   = wen_b_q;
  assign bus.WriteRegB  = wreg_b_q;
  assign bus.WriteDataB = wdat_b_q;
  assign start          = start_q;
  assign busy           = busy_q;
`ifdef REGFILE_LOADER_CHECKSUM_EN
  assign err            = err_q;
`else
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_loader.sv
// Bench for regfile_loader: per-cycle stimulus against a sequence-level model of the load protocol.
module tb_regfile_loader;

  localparam int NA = 8;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req = 1'b0;
  logic start, busy, err;

  regfile_loader_if bus ();

  regfile_loader #(.NUM_A(NA), .NUM_B(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_req (load_req),
    .bus      (bus.slave),
    .start    (start),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: where we are in the byte sequence, plus RUN/start/err bookkeeping.
  bit         m_loading;
  bit         m_run;
  bit         m_start;
  bit         m_err;
  int         m_idx;
  logic [7:0] m_xor;

  task automatic model_reset();
    m_loading = 0; m_run = 0; m_start = 0; m_err = 0; m_idx = 0; m_xor = 8'h00;
  endtask

  // One clock cycle: drive at negedge, check #1 after the following posedge, return at negedge.
  task automatic step(input bit lr, input bit v, input logic [7:0] d);
    bit xfer, exp_ea, exp_eb, start_next;
    int addr;
    n_tests++;
    if (bus.in_ready !== m_loading || busy !== m_loading) begin
      n_fail++;
      $display("FAIL ready_busy: in_ready=%b busy=%b expected %b", bus.in_ready, busy, m_loading);
    end
    load_req = lr; bus.in_valid = v; bus.in_data = d;
    @(posedge clk); #1;
    load_req = 1'b0; bus.in_valid = 1'b0;
    xfer = v && m_loading;
    exp_ea = 0; exp_eb = 0; addr = m_idx;
    start_next = m_run && !lr;
    m_run = m_run && !lr;
    if (lr && !m_loading) begin
      m_loading = 1; m_idx = 0; m_xor = 8'h00; m_err = 0;
    end else if (xfer) begin
      if (m_idx < NA) exp_ea = 1;
      else if (m_idx < NA + NB) exp_eb = 1;
      if (m_idx == NA + NB) begin
        if (d == m_xor) m_run = 1;
        else m_err = 1;
        m_loading = 0;
      end else begin
        m_xor = m_xor ^ d;
      end
      m_idx++;
`ifndef REGFILE_LOADER_CHECKSUM_EN
      if (m_idx == NA + NB) begin
        m_loading = 0; m_run = 1;
      end
`endif
    end
    m_start = start_next;
    n_tests++;
    if (bus.WriteEnA !== exp_ea || bus.WriteEnB !== exp_eb) begin
      n_fail++;
      $display("FAIL write_en: enA=%b enB=%b expected %b %b (idx %0d)", bus.WriteEnA, bus.WriteEnB, exp_ea, exp_eb, addr);
    end
    if (exp_ea) begin
      n_tests++;
      if (bus.WriteRegA !== addr[2:0] || bus.WriteDataA !== d[3:0]) begin
        n_fail++;
        $display("FAIL write_a: addr=%0d data=%h expected %0d %h", bus.WriteRegA, bus.WriteDataA, addr, d[3:0]);
      end
    end
    if (exp_eb) begin
      n_tests++;
      if (bus.WriteRegB !== 4'(addr - NA) || bus.WriteDataB !== d) begin
        n_fail++;
        $display("FAIL write_b: addr=%0d data=%h expected %0d %h", bus.WriteRegB, bus.WriteDataB, addr - NA, d);
      end
    end
    n_tests++;
    if (start !== m_start || err !== m_err) begin
      n_fail++;
      $display("FAIL start_err: start=%b err=%b expected %b %b", start, err, m_start, m_err);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0 || start !== 1'b0 || err !== 1'b0 ||
        bus.WriteEnA !== 1'b0 || bus.WriteEnB !== 1'b0 || bus.WriteRegA !== 3'd0 ||
        bus.WriteRegB !== 4'd0 || bus.WriteDataA !== 4'h0 || bus.WriteDataB !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: rdy=%b busy=%b start=%b err=%b enA=%b enB=%b regA=%h regB=%h datA=%h datB=%h expected all 0",
               name, bus.in_ready, busy, start, err, bus.WriteEnA, bus.WriteEnB,
               bus.WriteRegA, bus.WriteRegB, bus.WriteDataA, bus.WriteDataB);
    end
  endtask

  task automatic feed_random(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 8'($urandom));
  endtask

  // Checksum byte when the feature is built in; nothing otherwise.
  task automatic send_check(input bit good);
`ifdef REGFILE_LOADER_CHECKSUM_EN
    step(0, 1, good ? m_xor : (m_xor ^ 8'h01));
`else
    if (good) step(0, 0, 8'h00);
`endif
  endtask

  task automatic expect_start(input string name);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    n_tests++;
    if (start !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: start=%b busy=%b expected 1 0", name, start, busy);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(0, 1, 8'h55);
  endtask

  task automatic test_basic_load();
    step(1, 0, 8'h00);
    for (int i = 0; i < NA; i++) step(0, 1, 8'(i + 1));
    for (int i = 0; i < NB; i++) step(0, 1, 8'(8'h10 + i));
    send_check(1);
    expect_start("basic_start");
  endtask

  task automatic test_upper_nibble();
    step(1, 0, 8'h00);
    step(0, 1, 8'hF7);
    n_tests++;
    if (bus.WriteDataA !== 4'h7) begin
      n_fail++;
      $display("FAIL nibble: WriteDataA=%h expected 7", bus.WriteDataA);
    end
    feed_random(NA + NB - 1);
    send_check(1);
    expect_start("nibble_start");
  endtask

  task automatic test_stall();
    step(1, 0, 8'h00);
    feed_random(4);
    for (int i = 0; i < 3; i++) step(0, 0, 8'($urandom));
    feed_random(NA + NB - 4);
    send_check(1);
    expect_start("stall_start");
  endtask

  task automatic test_load_req_busy();
    step(1, 0, 8'h00);
    feed_random(NA + 3);
    step(1, 1, 8'($urandom));
    step(1, 0, 8'h00);
    feed_random(NB - 4);
    send_check(1);
    expect_start("ignored_req_start");
    step(1, 0, 8'h00);
    n_tests++;
    if (start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reload: start=%b busy=%b expected 0 1", start, busy);
    end
    feed_random(NA + NB);
    send_check(1);
    expect_start("reload_start");
  endtask

  task automatic test_reset_midload();
    step(1, 0, 8'h00);
    feed_random(10);
    rst = 1'b0;
    #1;
    check_all_zero("midload_reset");
    @(negedge clk);
    check_all_zero("midload_reset_hold");
    rst = 1'b1;
    model_reset();
    step(0, 1, 8'h3C);
    step(1, 0, 8'h00);
    step(0, 1, 8'hA5);
    feed_random(NA + NB - 1);
    send_check(1);
    expect_start("after_reset_start");
  endtask

  task automatic test_checksum();
    step(1, 0, 8'h00);
    feed_random(NA + NB);
    send_check(1);
    expect_start("csum_good_start");
`ifdef REGFILE_LOADER_CHECKSUM_EN
    step(1, 0, 8'h00);
    feed_random(NA + NB);
    send_check(0);
    step(0, 0, 8'h00);
    n_tests++;
    if (err !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL csum_bad: err=%b start=%b busy=%b rdy=%b expected 1 0 0 0", err, start, busy, bus.in_ready);
    end
    step(1, 0, 8'h00);
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL csum_err_clear: err=%b busy=%b expected 0 1", err, busy);
    end
    feed_random(NA + NB);
    send_check(1);
    expect_start("csum_recover_start");
`else
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_tied: err=%b expected 0", err);
    end
`endif
  endtask

  task automatic test_random();
    for (int l = 0; l < 4; l++) begin
      int guard = 0;
      step(1, 0, 8'h00);
      while (m_loading && guard < 400) begin
        step(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7), 8'($urandom));
        guard++;
      end
      n_tests++;
      if (m_loading) begin
        n_fail++;
        $display("FAIL random_bound: load %0d still busy after %0d cycles, expected done", l, guard);
      end
      for (int i = 0; i < 3; i++) step(($urandom_range(0, 3) == 0), 1, 8'($urandom));
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    model_reset();
    test_reset();
    test_basic_load();
    test_upper_nibble();
    test_stall();
    test_load_req_busy();
    test_reset_midload();
    test_checksum();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
